// File: rtl/md5_accel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package    : md5_accel_pkg                                         |
// | Description: Shared defaults, index-width helper and result record |
// |              for the MD5 accelerator result path.                  |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
package md5_accel_pkg;

   localparam int CAND_W_DEF    = 32;
   localparam int CNT_W_DEF     = 16;
   localparam int MAX_PIPELINES = 16;

   // Width of an index into n items; never less than one bit so that a
   // single-pipeline build still has a legal index port.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic [CAND_W_DEF-1:0]               candidate;
      logic [$clog2(MAX_PIPELINES)-1:0]    pipeline;
      logic [31:0]                         timestamp;
   } result_t;

endpackage : md5_accel_pkg
`default_nettype wire

// File: rtl/md5_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : md5_rr_arbiter                                        |
// | Description: Round-robin arbiter with an owned rotating pointer.   |
// |              Grant is the first request at or after the pointer.   |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
// | Ports                                                              |
// |   clk       in   clock                                             |
// |   rst       in   synchronous active-high reset (pointer -> 0)      |
// |   req       in   N request lines                                   |
// |   advance   in   current grant is consumed; pointer moves past it  |
// |   grant     out  one-hot grant                                     |
// |   grant_idx out  binary index of grant                             |
// |   any       out  at least one request present                      |
// +--------------------------------------------------------------------+
module md5_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   logic [IDX_W-1:0] ptr;

   // Scan N positions starting at the pointer, wrapping modulo N.
   always_comb begin : p_grant
      int j;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!any && req[j]) begin
            any       = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance && any) begin
         ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule : md5_rr_arbiter
`default_nettype wire

// File: rtl/md5_found_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : md5_found_collector                                   |
// | Description: Latches per-pipeline MD5 hits into slots, arbitrates  |
// |              them round-robin into a valid/ready result stream,    |
// |              and tracks hit count, overrun and completion.         |
// | Revision   : 1.0 - initial release                                 |
// | Option     : MD5_FOUND_TIMESTAMP_EN - per-hit 32-bit cycle stamp   |
// +--------------------------------------------------------------------+
// | Ports                                                              |
// |   CLK              in   system clock                               |
// |   CPU_RESET        in   synchronous active-high reset              |
// |   clear            in   synchronous flush (same effect as reset)   |
// |   each_found       in   per-pipeline one-cycle hit pulse           |
// |   candidates       in   flattened candidates, slice i*CAND_W       |
// |   status_done      in   driver search space exhausted (level)      |
// |   result_valid     out  result register holds a hit               |
// |   result_ready     in   consumer accept                            |
// |   result_candidate out  matching candidate                         |
// |   result_pipeline  out  source pipeline index                      |
// |   result_timestamp out  capture cycle stamp (0 when option off)    |
// |   found_count      out  saturating hit counter                     |
// |   overrun          out  sticky: a hit was dropped                  |
// |   all_reported     out  pulse: done, nothing pending or presented  |
// +--------------------------------------------------------------------+
module md5_found_collector
   import md5_accel_pkg::*;
#(
   parameter  int PIPELINES = 4,
   parameter  int CAND_W    = CAND_W_DEF,
   parameter  int CNT_W     = CNT_W_DEF,
   localparam int IDX_W     = idx_width(PIPELINES)
) (
   input  logic                          CLK,
   input  logic                          CPU_RESET,
   input  logic                          clear,
   input  logic [PIPELINES-1:0]          each_found,
   input  logic [PIPELINES*CAND_W-1:0]   candidates,
   input  logic                          status_done,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic [CAND_W-1:0]             result_candidate,
   output logic [IDX_W-1:0]              result_pipeline,
   output logic [31:0]                   result_timestamp,
   output logic [CNT_W-1:0]              found_count,
   output logic                          overrun,
   output logic                          all_reported
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                 sync_rst;
   logic [PIPELINES-1:0] pend;
   logic [PIPELINES-1:0] grant;
   logic [PIPELINES-1:0] freed;
   logic [PIPELINES-1:0] capture;
   logic [PIPELINES-1:0] lost;
   logic [IDX_W-1:0]     grant_idx;
   logic                 any_pend;
   logic                 advance;
   logic [4:0]           n_cap;
   logic [CNT_W+4:0]     cnt_sum;
   logic                 done_cond;
   logic                 done_cond_q;
   logic [CAND_W-1:0]    slot_cand [PIPELINES];

   assign sync_rst = CPU_RESET | clear;

   // The result register is free when empty or being handed off this cycle.
   assign advance = any_pend & (~result_valid | result_ready);

   md5_rr_arbiter #(
      .N     (PIPELINES),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk       (CLK),
      .rst       (sync_rst),
      .req       (pend),
      .advance   (advance),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any_pend)
   );

   // A slot accepts a hit if empty, or if it is being drained into the
   // result register on this very edge (the register reads the old value).
   always_comb begin
      freed   = grant & {PIPELINES{advance}};
      capture = each_found & (~pend | freed);
      lost    = each_found & ~capture;
      n_cap   = '0;
      for (int i = 0; i < PIPELINES; i++) begin
         n_cap = n_cap + 5'(capture[i]);
      end
      cnt_sum = {5'd0, found_count} + (CNT_W + 5)'(n_cap);
   end

   always_ff @(posedge CLK) begin
      if (sync_rst) begin
         pend        <= '0;
         found_count <= '0;
         overrun     <= 1'b0;
      end else begin
         pend    <= (pend & ~freed) | capture;
         overrun <= overrun | (|lost);
         if (cnt_sum > {5'd0, CNT_MAX}) begin
            found_count <= CNT_MAX;
         end else begin
            found_count <= cnt_sum[CNT_W-1:0];
         end
      end
   end

   // Slot contents are qualified by pend, so they need no reset.
   for (genvar gi = 0; gi < PIPELINES; gi++) begin : g_slot
      always_ff @(posedge CLK) begin
         if (capture[gi]) begin
            slot_cand[gi] <= candidates[gi*CAND_W +: CAND_W];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (sync_rst) begin
         result_valid     <= 1'b0;
         result_candidate <= '0;
         result_pipeline  <= '0;
      end else if (advance) begin
         result_valid     <= 1'b1;
         result_candidate <= slot_cand[grant_idx];
         result_pipeline  <= grant_idx;
      end else if (result_ready) begin
         result_valid     <= 1'b0;
      end
   end

`ifdef MD5_FOUND_TIMESTAMP_EN
   logic [31:0] cycle_ctr;
   logic [31:0] stamp_q;
   logic [31:0] slot_stamp [PIPELINES];

   always_ff @(posedge CLK) begin
      if (sync_rst) begin
         cycle_ctr <= '0;
      end else begin
         cycle_ctr <= cycle_ctr + 32'd1;
      end
   end

   for (genvar gs = 0; gs < PIPELINES; gs++) begin : g_stamp
      always_ff @(posedge CLK) begin
         if (capture[gs]) begin
            slot_stamp[gs] <= cycle_ctr;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (sync_rst) begin
         stamp_q <= '0;
      end else if (advance) begin
         stamp_q <= slot_stamp[grant_idx];
      end
   end

   assign result_timestamp = stamp_q;
`else
   assign result_timestamp = '0;
`endif

   // Completion pulse on the rising edge of "done and nothing left in flight".
   assign done_cond = status_done & ~(|pend) & ~result_valid & ~(|each_found);

   always_ff @(posedge CLK) begin
      if (sync_rst) begin
         done_cond_q <= 1'b0;
      end else begin
         done_cond_q <= done_cond;
      end
   end

   assign all_reported = done_cond & ~done_cond_q & ~sync_rst;

endmodule : md5_found_collector
`default_nettype wire

// File: tb/tb_md5_found_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : tb_md5_found_collector                                |
// | Description: Scoreboard bench for md5_found_collector. Stimulus    |
// |              pushes hand-computed results; a monitor pops and      |
// |              compares on every result handshake.                   |
// | Revision   : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module tb_md5_found_collector;

   localparam int P  = 4;
   localparam int CW = 32;
   localparam int NW = 16;

   logic            CLK          = 1'b0;
   logic            CPU_RESET    = 1'b1;
   logic            clear        = 1'b0;
   logic [P-1:0]    each_found   = '0;
   logic [P*CW-1:0] candidates   = '0;
   logic            status_done  = 1'b0;
   logic            result_ready = 1'b0;
   logic            result_valid;
   logic [CW-1:0]   result_candidate;
   logic [1:0]      result_pipeline;
   logic [31:0]     result_timestamp;
   logic [NW-1:0]   found_count;
   logic            overrun;
   logic            all_reported;

   typedef struct {
      logic [31:0] cand;
      logic [1:0]  pipe;
      logic [31:0] ts;
      logic        chk_ts;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   passed = 0;
   int   total  = 0;

   md5_found_collector #(
      .PIPELINES (P),
      .CAND_W    (CW),
      .CNT_W     (NW)
   ) dut (
      .CLK              (CLK),
      .CPU_RESET        (CPU_RESET),
      .clear            (clear),
      .each_found       (each_found),
      .candidates       (candidates),
      .status_done      (status_done),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .result_candidate (result_candidate),
      .result_pipeline  (result_pipeline),
      .result_timestamp (result_timestamp),
      .found_count      (found_count),
      .overrun          (overrun),
      .all_reported     (all_reported)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act === req) begin
         passed++;
      end else begin
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse(input logic [P-1:0] m);
      each_found = m;
      tick();
      each_found = '0;
   endtask

   task automatic set_cand(input int i, input logic [31:0] v);
      candidates[i*CW +: CW] = v;
   endtask

   task automatic push_exp(input logic [1:0] p, input logic [31:0] c,
                           input logic has_ts, input logic [31:0] ts);
      exp_t e;
      e.cand = c;
      e.pipe = p;
`ifdef MD5_FOUND_TIMESTAMP_EN
      e.chk_ts = has_ts;
      e.ts     = ts;
`else
      e.chk_ts = 1'b1;
      e.ts     = 32'd0;
      if (has_ts) e.ts = 32'd0;
`endif
      exp_q.push_back(e);
   endtask

   task automatic reset_dut();
      CPU_RESET = 1'b1;
      tick();
      tick();
      CPU_RESET = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || result_valid) && k < 200) begin
         tick();
         k++;
      end
      check("drain_done", {62'd0, exp_q.size() != 0, result_valid}, 64'd0);
   endtask

   // Monitor: the handshake completes on the next rising edge.
   always @(negedge CLK) begin
      if (!CPU_RESET && !clear && result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_result: actual pipe %0d cand %0h required none",
                     result_pipeline, result_candidate);
         end else begin
            mon_e = exp_q.pop_front();
            check("result_candidate", 64'(result_candidate), 64'(mon_e.cand));
            check("result_pipeline", 64'(result_pipeline), 64'(mon_e.pipe));
            if (mon_e.chk_ts) begin
               check("result_timestamp", 64'(result_timestamp), 64'(mon_e.ts));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] hold_cand;

      // Reset, with hits asserted to show reset overrides capture.
      each_found = 4'b1111;
      reset_dut();
      each_found = '0;
      check("rst_valid", 64'(result_valid), 64'd0);
      check("rst_cand", 64'(result_candidate), 64'd0);
      check("rst_pipe", 64'(result_pipeline), 64'd0);
      check("rst_ts", 64'(result_timestamp), 64'd0);
      check("rst_count", 64'(found_count), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_all_reported", 64'(all_reported), 64'd0);

      // Single hit on pipeline 2, two-cycle latency.
      result_ready = 1'b1;
      set_cand(2, 32'h0000_0100);
      push_exp(2'd2, 32'h0000_0100, 1'b0, 32'd0);
      pulse(4'b0100);
      check("single_lat1_valid", 64'(result_valid), 64'd0);
      check("single_count", 64'(found_count), 64'd1);
      tick();
      check("single_lat2_valid", 64'(result_valid), 64'd1);
      wait_idle();

      // Same slot pulsed on back-to-back cycles: freed as it refills.
      set_cand(2, 32'h0000_0201);
      push_exp(2'd2, 32'h0000_0201, 1'b0, 32'd0);
      pulse(4'b0100);
      set_cand(2, 32'h0000_0202);
      push_exp(2'd2, 32'h0000_0202, 1'b0, 32'd0);
      pulse(4'b0100);
      wait_idle();
      check("refill_overrun", 64'(overrun), 64'd0);
      check("refill_count", 64'(found_count), 64'd3);

      // Simultaneous hits 1011 from pointer 0.
      reset_dut();
      result_ready = 1'b1;
      set_cand(0, 32'h0000_00B0);
      set_cand(1, 32'h0000_00B1);
      set_cand(3, 32'h0000_00B3);
      push_exp(2'd0, 32'h0000_00B0, 1'b0, 32'd0);
      push_exp(2'd1, 32'h0000_00B1, 1'b0, 32'd0);
      push_exp(2'd3, 32'h0000_00B3, 1'b0, 32'd0);
      pulse(4'b1011);
      check("simul_count", 64'(found_count), 64'd3);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("simul_b2b_valid", 64'(result_valid), 64'd1);
      end
      wait_idle();

      // Backpressure with a wrap of the round-robin pointer.
      reset_dut();
      result_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_cand(i, 32'h0000_00A0 + 32'(i));
         push_exp(2'(i), 32'h0000_00A0 + 32'(i), 1'b0, 32'd0);
      end
      pulse(4'b1111);
      tick();
      check("bp_valid", 64'(result_valid), 64'd1);
      hold_cand = result_candidate;
      set_cand(0, 32'h0000_0A0B);
      push_exp(2'd0, 32'h0000_0A0B, 1'b0, 32'd0);
      pulse(4'b0001);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_stable", {result_valid, result_pipeline, result_candidate},
               {1'b1, 2'd0, 32'h0000_00A0});
      end
      check("bp_hold_first", 64'(hold_cand), 64'h0000_00A0);
      check("bp_count", 64'(found_count), 64'd5);
      check("bp_overrun", 64'(overrun), 64'd0);
      result_ready = 1'b1;
      wait_idle();

      // Overrun: pipeline 1 hit while its slot still waits.
      reset_dut();
      result_ready = 1'b0;
      set_cand(0, 32'h0000_00C0);
      push_exp(2'd0, 32'h0000_00C0, 1'b0, 32'd0);
      pulse(4'b0001);
      set_cand(1, 32'h0000_00C1);
      push_exp(2'd1, 32'h0000_00C1, 1'b0, 32'd0);
      pulse(4'b0010);
      set_cand(1, 32'h0000_00C2);
      pulse(4'b0010);
      check("ovr_overrun", 64'(overrun), 64'd1);
      check("ovr_count", 64'(found_count), 64'd2);
      result_ready = 1'b1;
      wait_idle();
      check("ovr_sticky", 64'(overrun), 64'd1);

      // Completion pulse after the last handshake.
      reset_dut();
      result_ready = 1'b0;
      status_done  = 1'b1;
      set_cand(0, 32'h0000_00D0);
      set_cand(1, 32'h0000_00D1);
      push_exp(2'd0, 32'h0000_00D0, 1'b0, 32'd0);
      push_exp(2'd1, 32'h0000_00D1, 1'b0, 32'd0);
      pulse(4'b0011);
      check("done_pending", 64'(all_reported), 64'd0);
      tick();
      tick();
      check("done_holding", 64'(all_reported), 64'd0);
      result_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("done_pulse", 64'(all_reported), (i == 1) ? 64'd1 : 64'd0);
      end
      status_done = 1'b0;
      wait_idle();

      // Clear mid-operation, overriding same-cycle hits.
      reset_dut();
      result_ready = 1'b0;
      set_cand(0, 32'h0000_00E0);
      set_cand(1, 32'h0000_00E1);
      set_cand(2, 32'h0000_00E2);
      pulse(4'b0111);
      tick();
      pulse(4'b0010);
      check("pre_clr_state", {result_valid, overrun, result_pipeline}, {1'b1, 1'b1, 2'd0});
      clear      = 1'b1;
      each_found = 4'b1111;
      tick();
      clear      = 1'b0;
      each_found = '0;
      check("clr_valid", 64'(result_valid), 64'd0);
      check("clr_cand", 64'(result_candidate), 64'd0);
      check("clr_pipe", 64'(result_pipeline), 64'd0);
      check("clr_count", 64'(found_count), 64'd0);
      check("clr_overrun", 64'(overrun), 64'd0);
      result_ready = 1'b1;
      tick();
      tick();
      check("clr_no_stale", 64'(result_valid), 64'd0);
      set_cand(3, 32'h0000_00E3);
      push_exp(2'd3, 32'h0000_00E3, 1'b1, 32'd2);
      pulse(4'b1000);
      check("clr_count_after", 64'(found_count), 64'd1);
      wait_idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_md5_found_collector
`default_nettype wire

// File: doc/md5_found_collector.md
Name: md5_found_collector

Overview:
- Sits directly downstream of the MD5 accelerator driver.
- Consumes the per-pipeline `each_found` pulses and each pipeline's current 32-bit candidate, and latches every hit.
- Round-robin arbitrates hits into one valid/ready result stream for the CPU/AXI register front-end.
- Tracks hit count, overruns, and "search finished and fully reported".

Parameters:
PIPELINES, 4, number of hashing pipelines; matches driver PIPELINES (1..16)
CAND_W, 32, candidate word width
CNT_W, 16, width of saturating hit counter

Ports:
CLK  in  1  system clock, all logic rising-edge
CPU_RESET  in  1  synchronous active-high reset
clear  in  1  sync flush: drop pending/output, zero counter and flags
each_found  in  PIPELINES  per-pipeline one-cycle hit pulse from driver
candidates  in  PIPELINES*CAND_W  flattened candidate per pipeline, slice i = [i*CAND_W +: CAND_W], valid in the cycle each_found[i]=1
status_done  in  1  driver search-space exhausted (level)
result_valid  out  1  result register holds a hit
result_ready  in  1  consumer accepts when valid&ready
result_candidate  out  CAND_W  candidate that matched
result_pipeline  out  clog2(PIPELINES) (min 1)  index of source pipeline
result_timestamp  out  32  cycle stamp of the hit (see Optional Feature)
found_count  out  CNT_W  hits latched since reset/clear, saturating at all-ones
overrun  out  1  sticky: a hit was lost
all_reported  out  1  one-cycle pulse: status_done high, no pending, no result_valid

Behaviour:
- Reset values (CPU_RESET, or clear, sync):
  - result_valid=0; result_candidate, result_pipeline, result_timestamp=0.
  - found_count=0; overrun=0; all_reported=0; all pending bits 0; RR pointer=0.
- Capture stage, per pipeline i:
  - each_found[i]=1 with pend[i]=0: set pend[i], store candidate slice (and stamp) in slot i; found_count+1 (saturating).
  - each_found[i]=1 with pend[i]=1: new hit dropped, slot keeps the old value, overrun set, count unchanged.
  - Same-cycle pulse on multiple pipelines: all captured in that cycle.
  - Slot freed in the same cycle it receives a new pulse: the new hit is captured, no overrun.
- Arbitration:
  - Result register loads when result_valid=0, or when result_valid & result_ready (back-to-back, no bubble).
  - Grant = first pend[j] at or after the RR pointer (mod PIPELINES).
  - Granted slot's pend clears on load; pointer moves to grant+1 (wraps to 0 after PIPELINES-1).
  - Latency: each_found to result_valid = 2 cycles when idle (capture edge, then load edge).
- Handshake:
  - result_* hold stable while valid & !ready.
  - valid does not drop without a handshake except on reset/clear.
- all_reported:
  - Rises on the first cycle status_done=1 & pend==0 & !result_valid & no each_found.
  - Pulses once per rising edge of that condition.
- found_count holds at 2^CNT_W-1 once saturated.
- clear and CPU_RESET behave identically. Both override same-cycle each_found.

Optional Feature:
- Macro MD5_FOUND_TIMESTAMP_EN.
  - Defined: a free-running 32-bit cycle counter (reset/clear to 0, wraps) is stored per slot at capture; result_timestamp shows the granted slot's stamp.
  - Undefined: no counter or stamp storage; result_timestamp tied to 0.

Decomposition:
- Package md5_accel_pkg:
  - CAND_W default; CNT_W default.
  - clog2-based index-width function.
  - Result struct typedef (candidate, pipeline, timestamp).
- Sub-module md5_rr_arbiter:
  - Parameter N.
  - Inputs req[N], advance; outputs grant one-hot, grant index, any.
  - Owns the rotating pointer.

Test Plan:
- Single hit: each_found=4'b0100, candidate[2]=32'h00000100, ready=1 → result_valid at +2 cycles, candidate 32'h00000100, pipeline 2, found_count=1.
- Simultaneous hits: each_found=4'b1011 in one cycle, ready=1 → three results in consecutive cycles, pipelines 0,1,3, found_count=3.
- Backpressure: ready=0 for 10 cycles with valid high → outputs stable; after ready=1, remaining hits drain in RR order from pointer.
- Overrun: pipeline 1 pulses twice while its first hit waits (ready=0) → overrun=1, found_count=1, delivered candidate is the first value.
- Done reporting: status_done=1 with two pending hits, ready=1 → all_reported pulses exactly once, on the cycle after the last handshake.
- clear mid-operation with result_valid=1 and pend=4'b0110 → next cycle all zero; next hit on pipeline 3 → found_count=1; with MD5_FOUND_TIMESTAMP_EN its timestamp counts from the clear.
